controller: RTL and testbench

Instruction sequencer of the VeriRISC CPU. Steps each instruction through eight fixed phases and, from the current phase and the decoded `opcode`, drives the control strobes for the memory mux, instruction register, program counter, accumulator and ALU. It consumes the ALU's `zero` flag. It halts on `HLT` and keeps a retired-instruction counter for bring-up.

---
 rtl/controller_pkg.sv | 38 +++
 rtl/controller_if.sv | 38 +++
 rtl/controller.sv | 140 ++++++++++++++
 tb/tb_controller.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared VeriRISC encodings: opcodes, sequencer states and the ALU-class helper.
// Included by the controller, its bus interface and the bench, so waveforms and
// checks agree on the encodings.
package typedefs;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_t;

  // Opcodes whose operand is read from memory into the accumulator path.
  // Unknown (X/Z) opcodes fall to the default and count as non-ALU.
  function automatic logic is_aluop(input opcode_t op);
    case (op)
      ADD, AND, XOR, LDA: return 1'b1;
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/controller_if.sv
// Controller <-> datapath strobe bundle. The master side is the controller.
// The resume line exists only when CONTROLLER_STEP_EN is defined.
interface controller_if #(parameter int COUNT_WIDTH = 16);
  import typedefs::*;

  opcode_t                 opcode;
  logic                    zero;
`ifdef CONTROLLER_STEP_EN
  logic                    resume;
`endif
  logic                    sel;
  logic                    rd;
  logic                    ld_ir;
  logic                    inc_pc;
  logic                    ld_pc;
  logic                    ld_ac;
  logic                    wr;
  logic                    data_e;
  logic                    halt;
  logic [COUNT_WIDTH-1:0]  instr_count;

  modport master (
`ifdef CONTROLLER_STEP_EN
    input  resume,
`endif
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, instr_count
  );

  modport slave (
`ifdef CONTROLLER_STEP_EN
    output resume,
`endif
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, instr_count
  );

endinterface

// File: rtl/controller.sv
// VeriRISC instruction sequencer: eight-phase FSM, strobe decoder and
// retired-instruction counter. Strobes are decoded from the registered state
// and the IR opcode, so they settle after posedge and are stable at the ALU's
// negedge sample. Optional single-step/resume support: CONTROLLER_STEP_EN.
// COUNT_WIDTH must match the COUNT_WIDTH of the connected controller_if.
module controller
  import typedefs::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  controller_if.master bus
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state;
  logic [COUNT_WIDTH-1:0] instr_count;

  logic op_hlt;
  logic op_skz;
  logic op_sto;
  logic op_jmp;
  logic op_alu;

  // Opcode class flags; X/Z opcodes land in the default and assert nothing.
  always_comb begin
    op_hlt = 1'b0;
    op_skz = 1'b0;
    op_sto = 1'b0;
    op_jmp = 1'b0;
    op_alu = is_aluop(bus.opcode);
    case (bus.opcode)
      HLT:     op_hlt = 1'b1;
      SKZ:     op_skz = 1'b1;
      STO:     op_sto = 1'b1;
      JMP:     op_jmp = 1'b1;
      default: op_hlt = 1'b0;
    endcase
  end

  // Phase sequencing and retired-instruction counting (HLT retires on entry to HALTED).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INST_ADDR;
      instr_count <= '0;
    end else begin
      case (state)
        INST_ADDR:  state <= INST_FETCH;
        INST_FETCH: state <= INST_LOAD;
        INST_LOAD:  state <= IDLE;
        IDLE:       state <= OP_ADDR;
        OP_ADDR: begin
          if (op_hlt) begin
            state       <= HALTED;
            instr_count <= instr_count + COUNT_ONE;
          end else begin
            state <= OP_FETCH;
          end
        end
        OP_FETCH:   state <= ALU_OP;
        ALU_OP:     state <= STORE;
        STORE: begin
          state       <= INST_ADDR;
          instr_count <= instr_count + COUNT_ONE;
        end
        HALTED: begin
`ifdef CONTROLLER_STEP_EN
          if (bus.resume) begin
            state <= INST_ADDR;
          end else begin
            state <= HALTED;
          end
`else
          state <= HALTED;
`endif
        end
        default:    state <= INST_ADDR;
      endcase
    end
  end

  // Strobe decode per phase; anything not named for a phase stays 0.
  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.wr     = 1'b0;
    bus.data_e = 1'b0;
    bus.halt   = 1'b0;
    case (state)
      INST_ADDR: begin
        bus.sel = 1'b1;
      end
      INST_FETCH: begin
        bus.sel = 1'b1;
        bus.rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        bus.sel   = 1'b1;
        bus.rd    = 1'b1;
        bus.ld_ir = 1'b1;
      end
      OP_ADDR: begin
        bus.inc_pc = 1'b1;
        bus.halt   = op_hlt;
      end
      OP_FETCH: begin
        bus.rd = op_alu;
      end
      ALU_OP: begin
        // SKZ skip is a second PC increment on top of the OP_ADDR one.
        bus.rd     = op_alu;
        bus.inc_pc = op_skz & bus.zero;
        bus.ld_pc  = op_jmp;
        bus.data_e = op_sto;
      end
      STORE: begin
        bus.rd     = op_alu;
        bus.ld_ac  = op_alu;
        bus.ld_pc  = op_jmp;
        bus.wr     = op_sto;
        bus.data_e = op_sto;
      end
      HALTED: begin
        bus.halt = 1'b1;
      end
      default: begin
        bus.sel = 1'b0;
      end
    endcase
  end

  assign bus.instr_count = instr_count;

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for the VeriRISC controller. The driver issues one cycle of
// stimulus at a time and pushes the strobes/count expected for that cycle,
// derived from the phase table and retirement rules; negedge monitors pop and
// compare. A second instance with COUNT_WIDTH=2 exercises counter wrap.
`timescale 1ns/1ps
module tb_controller;
  import typedefs::*;

  typedef struct {
    logic [8:0]  strobes;
    logic [15:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;

  controller_if #(.COUNT_WIDTH(16)) bus ();
  controller_if #(.COUNT_WIDTH(2))  bus2 ();

  controller #(.COUNT_WIDTH(16)) dut  (.clk(clk), .rst(rst),  .bus(bus));
  controller #(.COUNT_WIDTH(2))  dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  always #5 clk = ~clk;

  exp_t       q[$];
  logic [1:0] q2[$];
  int         errors = 0;
  int         checks = 0;
  int         retired = 0;

  // Reference phase table: phase 0..7 of an instruction, opcode known.
  function automatic logic [8:0] exp_vec(input int ph, input int op, input logic z);
    logic alu, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
    alu    = (op >= 2) && (op <= 5);
    sel    = (ph <= 3);
    rd     = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    ld_ir  = (ph == 2) || (ph == 3);
    inc_pc = (ph == 4) || (ph == 6 && op == 1 && z);
    ld_pc  = (op == 7) && (ph == 6 || ph == 7);
    ld_ac  = alu && (ph == 7);
    wr     = (op == 6) && (ph == 7);
    data_e = (op == 6) && (ph == 6 || ph == 7);
    halt   = (ph == 4) && (op == 0);
    return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
  endfunction

  function automatic logic [8:0] halted_vec();
    logic [8:0] v;
    v = 9'b0_0000_0001;
    return v;
  endfunction

  task automatic expect_cycle(input logic [8:0] s);
    exp_t e;
    e.strobes = s;
    e.count   = 16'(retired);
    q.push_back(e);
  endtask

  // One clock of stimulus, applied just after posedge.
  task automatic drive(input logic r, input logic [2:0] op, input logic z);
    @(posedge clk);
    #1;
    rst = r;
    bus.opcode = opcode_t'(op);
    bus.zero = z;
  endtask

  task automatic do_reset(input bit with_resume);
    drive(1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
`ifdef CONTROLLER_STEP_EN
    bus.resume = with_resume;
`else
    if (with_resume) bus.zero = 1'b0;
`endif
    drive(1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
`ifdef CONTROLLER_STEP_EN
    bus.resume = with_resume;
`endif
    retired = 0;
    expect_cycle(exp_vec(0, 2, 1'b0));
  endtask

  // Run nph phases of a non-HLT instruction; early phases see random opcodes.
  task automatic run_instr(input int op, input logic z, input int nph);
    for (int ph = 0; ph < nph; ph++) begin
      if (ph < 4) drive(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      else        drive(1'b0, 3'(op), z);
`ifdef CONTROLLER_STEP_EN
      bus.resume = 1'($urandom_range(0, 1));
`endif
      expect_cycle(exp_vec(ph, (ph < 4) ? int'(bus.opcode) : op, bus.zero));
    end
    if (nph == 8) retired++;
  endtask

  task automatic run_halt(input int hold);
    for (int ph = 0; ph < 5; ph++) begin
      if (ph < 4) drive(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      else        drive(1'b0, 3'd0, 1'($urandom_range(0, 1)));
`ifdef CONTROLLER_STEP_EN
      bus.resume = 1'($urandom_range(0, 1));
`endif
      expect_cycle(exp_vec(ph, int'(bus.opcode), bus.zero));
    end
    retired++;
    for (int i = 0; i < hold; i++) begin
      drive(1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
`ifdef CONTROLLER_STEP_EN
      bus.resume = 1'b0;
`endif
      expect_cycle(halted_vec());
    end
  endtask

  // Monitor for the main instance.
  initial begin
    exp_t e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc, bus.ld_ac,
               bus.wr, bus.data_e, bus.halt};
        checks++;
        if (act !== e.strobes) begin
          errors++;
          $display("FAIL strobes t=%0t got=%b want=%b (sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt)",
                   $time, act, e.strobes);
        end
        checks++;
        if (bus.instr_count !== e.count) begin
          errors++;
          $display("FAIL instr_count t=%0t got=%0d want=%0d", $time, bus.instr_count, e.count);
        end
      end
    end
  end

  // Monitor for the wrap instance.
  initial begin
    logic [1:0] c;
    forever begin
      @(negedge clk);
      if (q2.size() > 0) begin
        c = q2.pop_front();
        checks++;
        if (bus2.instr_count !== c) begin
          errors++;
          $display("FAIL wrap_count t=%0t got=%0d want=%0d", $time, bus2.instr_count, c);
        end
      end
    end
  end

  initial begin
    bus.opcode = ADD;
    bus.zero = 1'b0;
    bus2.opcode = ADD;
    bus2.zero = 1'b0;
`ifdef CONTROLLER_STEP_EN
    bus.resume = 1'b0;
    bus2.resume = 1'b0;
`endif

    do_reset(1'b0);
    // Directed: ADD, SKZ taken/not taken, STO, JMP.
    run_instr(2, 1'b0, 8);
    run_instr(1, 1'b1, 8);
    run_instr(1, 1'b0, 8);
    run_instr(6, 1'b0, 8);
    run_instr(7, 1'b1, 8);
    // Random non-HLT instructions.
    for (int i = 0; i < 30; i++) begin
      run_instr($urandom_range(1, 7), 1'($urandom_range(0, 1)), 8);
    end
    // Reset mid-instruction.
    run_instr(6, 1'b0, 7);
    do_reset(1'b0);
    run_instr(3, 1'b0, 8);
    // HLT holds for 20 clocks.
    run_halt(20);
`ifdef CONTROLLER_STEP_EN
    // One-cycle resume pulse: INST_ADDR on the next clock.
    drive(1'b0, 3'd0, 1'b0);
    bus.resume = 1'b1;
    expect_cycle(halted_vec());
    run_instr(4, 1'b0, 8);
    run_halt(3);
`endif
    // Reset while halted, with resume raised at the same time.
    do_reset(1'b1);
    run_instr(5, 1'b1, 8);
    run_instr(2, 1'b0, 8);
    run_halt(4);
    do_reset(1'b0);
    run_instr(2, 1'b0, 8);

    // Wrap check on the 2-bit counter: 5 ADDs give 1, 2, 3, 0, 1.
    @(posedge clk);
    #1;
    rst2 = 1'b0;
    q2.push_back(2'd0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      q2.push_back(2'((c / 8) % 4));
    end

    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
